// File: rtl/tpu_pkg.sv
// Shared TPU datapath types and constants.
// Used by the operand sequencer, operand mux and downstream stages.
package tpu_pkg;

  localparam int   TPU_WIDTH  = 32;
  localparam logic SEL_WEIGHT = 1'b0;
  localparam logic SEL_ACT    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM_A,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/tpu_pipe_reg.sv
// One-entry valid/ready pipeline register.
// Holds its beat while stalled; reloads with no bubble on accept.
module tpu_pipe_reg #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             can_load
);

  assign can_load = !out_valid || out_ready;

  // Capture a new beat, or empty the slot once downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tpu_operand_sequencer.sv
// Operand sequencer: weight burst then activation stream
// through one registered port feeding the operand mux.
module tpu_operand_sequencer
  import tpu_pkg::*;
#(
  parameter int WIDTH     = TPU_WIDTH,
  parameter int N_WEIGHTS = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_act,
  input  logic [WIDTH-1:0] w_data,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(N_WEIGHTS - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] a_cnt;
  logic [CNT_W-1:0] act_total;

  logic             can_load;
  logic             w_fire;
  logic             a_fire;
  logic             load;
  logic [WIDTH:0]   load_beat;
  logic [WIDTH:0]   reg_q;

  assign w_ready = (state == LOAD_W) && can_load;
  assign a_ready = (state == STREAM_A) && can_load;
  assign w_fire  = w_valid && w_ready;
  assign a_fire  = a_valid && a_ready;
  assign load    = w_fire || a_fire;

  assign load_beat = w_fire ? {SEL_WEIGHT, w_data}
                            : {SEL_ACT, a_data};

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign out_sel  = reg_q[WIDTH];
  assign out_data = reg_q[WIDTH-1:0];

  tpu_pipe_reg #(
    .WIDTH(WIDTH + 1)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .in_data  (load_beat),
    .out_ready(out_ready),
    .out_data (reg_q),
    .out_valid(out_valid),
    .can_load (can_load)
  );

  // Job FSM: weights, then activations, then wait for the output to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_cnt     <= '0;
      a_cnt     <= '0;
      act_total <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_W;
            act_total <= num_act;
            w_cnt     <= '0;
            a_cnt     <= '0;
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            w_cnt <= w_cnt + 1'b1;
            if (w_cnt == W_LAST)
              state <= (act_total == '0) ? DRAIN : STREAM_A;
          end
        end
        STREAM_A: begin
          if (a_fire) begin
            a_cnt <= a_cnt + 1'b1;
            if (a_cnt == act_total - 1'b1)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (can_load)
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_operand_sequencer.sv
// Randomised bench for the operand sequencer.
// Reference: expected beat queue built from the source data.
module tb_tpu_operand_sequencer;

  localparam int W  = 32;
  localparam int NW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_act;
  logic [W-1:0]  w_data;
  logic          w_valid;
  logic          w_ready;
  logic [W-1:0]  a_data;
  logic          a_valid;
  logic          a_ready;
  logic [W-1:0]  out_data;
  logic          out_sel;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tpu_operand_sequencer #(
    .WIDTH    (W),
    .N_WEIGHTS(NW),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_act  (num_act),
    .w_data   (w_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, 64'({out_data, out_sel, out_valid, w_ready,
                    a_ready, busy, done}), 64'(0));
  endtask

  task automatic run_job(input int na, input int a_pct,
                         input int o_pct, input bit stall,
                         input bit poke, input bit lat,
                         input int abort_at);
    logic [32:0] exp_q[$];
    logic [31:0] wv[NW];
    logic [31:0] av[$];
    logic [32:0] hold_v;
    int wi = 0, ai = 0, nsel1 = 0, stall_left = 0;
    int budget = 20 * (na + NW) + 100;
    bit stalled_once = 0, held = 0, fin = 0, aborted = 0;

    for (int i = 0; i < NW; i++) begin
      wv[i] = $urandom;
      exp_q.push_back({1'b0, wv[i]});
    end
    for (int i = 0; i < na; i++) begin
      av.push_back($urandom);
      exp_q.push_back({1'b1, av[i]});
    end

    @(negedge clk);
    start     = 1'b1;
    num_act   = CW'(na);
    w_valid   = 1'b1;
    w_data    = wv[0];
    a_valid   = 1'(($urandom_range(0, 1)));
    a_data    = $urandom;
    out_ready = 1'b1;
    #1;

    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      check("busy", 64'(busy), 64'(cyc > 0));
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_beat", 64'({out_sel, out_data}), 64'(hold_v));
      end
      held   = out_valid && !out_ready;
      hold_v = {out_sel, out_data};
      if (held)
        check("bp_ready", 64'({w_ready, a_ready}), 64'(0));
      if (wi == NW)
        check("w_ready_off", 64'(w_ready), 64'(0));
      if (wi < NW || ai == na)
        check("a_ready_off", 64'(a_ready), 64'(0));
      if (done) begin
        if (lat)
          check("done_lat", 64'(cyc), 64'(NW + na + 2));
        fin = 1;
      end

      if (w_valid && w_ready) wi++;
      if (a_valid && a_ready) ai++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          check("extra_beat", 64'(1), 64'(0));
        else
          check("beat", 64'({out_sel, out_data}),
                64'(exp_q.pop_front()));
        if (out_sel) nsel1++;
      end

      if (abort_at > 0 && ai >= abort_at && ai < na && out_valid) begin
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_async");
        aborted = 1;
        break;
      end

      @(negedge clk);
      start   = (poke && cyc == 5);
      num_act = CW'($urandom);
      w_valid = (wi < NW) ? 1'b1 : 1'(($urandom_range(0, 1)));
      w_data  = (wi < NW) ? wv[wi] : $urandom;
      a_valid = ($urandom_range(0, 99) < a_pct);
      a_data  = (ai < na) ? av[ai] : $urandom;
      if (stall && !stalled_once && wi == 4) begin
        stall_left   = 3;
        stalled_once = 1;
      end
      out_ready = (stall_left > 0) ? 1'b0
                : ($urandom_range(0, 99) < o_pct);
      if (stall_left > 0) stall_left--;
      #1;
    end

    if (aborted) begin
      repeat (2) @(negedge clk);
      check_reset_outs("rst_hold");
      start   = 1'b0;
      w_valid = 1'b1;
      a_valid = 1'b1;
      rst_n   = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #1;
        check("no_done_after_rst", 64'({done, busy, out_valid}), 64'(0));
      end
      return;
    end

    if (!fin) check("timeout", 64'(0), 64'(1));
    check("beats_left", 64'(exp_q.size()), 64'(0));
    check("act_beats", 64'(nsel1), 64'(na));
    check("idle_after", 64'({busy, done, out_valid, w_ready, a_ready}),
          64'(0));
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_act   = '0;
    w_data    = '0;
    w_valid   = 1'b0;
    a_data    = '0;
    a_valid   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outs("post_reset");

    run_job(4,    100, 100, 0, 0, 1, 0);
    run_job(6,    100, 100, 1, 0, 0, 0);
    run_job(0,    100, 100, 0, 0, 1, 0);
    run_job(1000, 50,  100, 0, 1, 0, 0);
    run_job(20,   100, 100, 0, 0, 0, 3);
    run_job(5,    100, 100, 0, 0, 1, 0);
    run_job(1,    100, 100, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++)
      run_job(int'($urandom_range(0, 40)), 70, 60, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
